i2c_txff_gen: RTL

//  Parametrised I2C transmit FIFO, successor of the fixed 16x8 TX FIFO. APB side writes bytes;
//  I2C shift engine reads them. Adds programmable depth/width, occupancy level, watermark irq,

---
 rtl/i2c_txff_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/i2c_txff_gen.sv
// Parametrised I2C transmit FIFO between the APB register block and the I2C shifter.
// First-word-fall-through read port, occupancy level, watermark irq and sticky ov/ud flags.
module i2c_txff_gen #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int THR_RST = 0
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              thr_we,
  input  logic [ADDR_W:0]   thr_val,
  input  logic              flag_clr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              thr_irq,
  output logic              ov,
  output logic              ud
);

  localparam int            DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] THR_R   = (ADDR_W + 1)'(THR_RST);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr, rptr, wptr_nxt, rptr_nxt;
  logic [ADDR_W:0]   thr_q, thr_nxt, level_nxt;
  logic              wr_acc, rd_acc, ov_set, ud_set;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign level   = wptr - rptr;
  assign rd_data = mem[rptr[ADDR_W-1:0]];

  // Flush suppresses acceptance and flag events alike.
  assign rd_acc = rd_en & ~empty & ~flush;
  assign wr_acc = wr_en & (~full | rd_acc) & ~flush;
  assign ov_set = wr_en & ~wr_acc & ~flush;
  assign ud_set = rd_en & empty & ~flush;

  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (wr_acc) wptr_nxt = wptr + 1'b1;
      if (rd_acc) rptr_nxt = rptr + 1'b1;
    end
  end

  always_comb begin
    thr_nxt = thr_q;
    if (thr_we) thr_nxt = (thr_val > DEPTH_L) ? DEPTH_L : thr_val;
  end

  // Irq is computed from next-state values so it lines up with the level output.
  assign level_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      thr_q   <= THR_R;
      thr_irq <= 1'b1;
      ov      <= 1'b0;
      ud      <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      thr_q   <= thr_nxt;
      thr_irq <= (level_nxt <= thr_nxt);
      ov      <= ov_set | (ov & ~flag_clr);
      ud      <= ud_set | (ud & ~flag_clr);
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_acc) mem[wptr[ADDR_W-1:0]] <= wr_data;
  end

endmodule
